// File: rtl/qam_mapper_pkg.sv
// Shared definitions for the streaming QAM mapper: mode and state encodings,
// bits-per-symbol helper and the 802.11 Gray level tables.
package qam_mapper_pkg;

  typedef enum logic [1:0] {
    MODE_BPSK  = 2'd0,
    MODE_QPSK  = 2'd1,
    MODE_16QAM = 2'd2,
    MODE_64QAM = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int LEVEL_W = 4;

  // Indexed by {b0,b1} (b0 is the index MSB).
  localparam logic signed [LEVEL_W-1:0] GRAY16_LEVEL [4] = '{
    -4'sd3, -4'sd1, 4'sd3, 4'sd1
  };

  // Indexed by {b0,b1,b2} (b0 is the index MSB).
  localparam logic signed [LEVEL_W-1:0] GRAY64_LEVEL [8] = '{
    -4'sd7, -4'sd5, -4'sd1, -4'sd3, 4'sd7, 4'sd5, 4'sd1, 4'sd3
  };

  function automatic logic [2:0] nbps(input mode_t mode);
    case (mode)
      MODE_BPSK:  nbps = 3'd1;
      MODE_QPSK:  nbps = 3'd2;
      MODE_16QAM: nbps = 3'd4;
      MODE_64QAM: nbps = 3'd6;
      default:    nbps = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/qam_mapper_stream_level_lut.sv
// Combinational Gray-coded level lookup: up to 6 symbol bits (LSB first in
// time) plus mode give the unscaled signed I/Q constellation levels.
module qam_level_lut
  import qam_mapper_pkg::*;
(
  input  logic [5:0]                bits,
  input  mode_t                     mode,
  output logic signed [LEVEL_W-1:0] level_i,
  output logic signed [LEVEL_W-1:0] level_q
);

  // Level decode per modulation order
  always_comb begin
    level_i = -4'sd1;
    level_q = 4'sd0;
    case (mode)
      MODE_BPSK: begin
        level_i = bits[0] ? 4'sd1 : -4'sd1;
        level_q = 4'sd0;
      end
      MODE_QPSK: begin
        level_i = bits[0] ? 4'sd1 : -4'sd1;
        level_q = bits[1] ? 4'sd1 : -4'sd1;
      end
      MODE_16QAM: begin
        level_i = GRAY16_LEVEL[{bits[0], bits[1]}];
        level_q = GRAY16_LEVEL[{bits[2], bits[3]}];
      end
      MODE_64QAM: begin
        level_i = GRAY64_LEVEL[{bits[0], bits[1], bits[2]}];
        level_q = GRAY64_LEVEL[{bits[3], bits[4], bits[5]}];
      end
      default: begin
        level_i = -4'sd1;
        level_q = 4'sd0;
      end
    endcase
  end

endmodule

// File: rtl/qam_mapper_stream.sv
// Streaming constellation mapper: packs input words into a bit buffer, peels
// off 1/2/4/6 bits per symbol and emits scaled Gray-coded I/Q with framing.
module qam_mapper_stream
  import qam_mapper_pkg::*;
#(
  parameter int DIN_W      = 8,
  parameter int OUT_W      = 8,
  parameter int UNIT_BPSK  = 64,
  parameter int UNIT_QPSK  = 45,
  parameter int UNIT_16QAM = 20,
  parameter int UNIT_64QAM = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              cfg_mode,
  input  logic [DIN_W-1:0]        s_tdata,
  input  logic                    s_tvalid,
  input  logic                    s_tlast,
  output logic                    s_tready,
  output logic signed [OUT_W-1:0] m_tdata_i,
  output logic signed [OUT_W-1:0] m_tdata_q,
  output logic                    m_tvalid,
  output logic                    m_tlast,
  input  logic                    m_tready,
  output logic [15:0]             sym_count,
  output logic                    busy
);

  localparam int BUF_W  = DIN_W + 6;
  localparam int CNT_W  = $clog2(BUF_W + 1);
  localparam int PROD_W = OUT_W + 4;
  localparam logic [CNT_W-1:0] CNT_ROOM = CNT_W'(BUF_W - DIN_W);
  localparam logic [CNT_W-1:0] CNT_DIN  = CNT_W'(DIN_W);
  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(-(2 ** (OUT_W - 1)));

  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [PROD_W-1:0] v);
    if (v > SAT_MAX) begin
      saturate = SAT_MAX[OUT_W-1:0];
    end else if (v < SAT_MIN) begin
      saturate = SAT_MIN[OUT_W-1:0];
    end else begin
      saturate = v[OUT_W-1:0];
    end
  endfunction

  state_t                    state_r, state_next_s;
  mode_t                     mode_r, mode_next_s;
  logic [BUF_W-1:0]          buf_r, buf_next_s, buf_after_s, word_ext_s;
  logic [CNT_W-1:0]          cnt_r, cnt_next_s, cnt_after_s, nbps_cnt_s;
  logic [2:0]                nbps_s;
  logic                      out_free_s, accept_s, extract_s, last_s;
  logic                      s_tready_r, s_tready_next_s;
  logic                      m_tvalid_r, m_tvalid_next_s, m_tlast_r;
  logic                      busy_r;
  logic [15:0]               sym_count_r;
  logic signed [OUT_W-1:0]   data_i_r, data_q_r;
  logic [5:0]                bits_s;
  logic signed [LEVEL_W-1:0] lvl_i_s, lvl_q_s;
  logic signed [PROD_W-1:0]  unit_s, prod_i_s, prod_q_s;

  // Next-state, buffer bookkeeping and handshake decisions
  always_comb begin
    nbps_s       = nbps(mode_r);
    nbps_cnt_s   = CNT_W'(nbps_s);
    out_free_s   = !m_tvalid_r || m_tready;
    accept_s     = s_tvalid && s_tready_r && (state_r != DRAIN);
    extract_s    = 1'b0;
    last_s       = 1'b0;
    state_next_s = state_r;
    mode_next_s  = mode_r;

    // A short remainder is only flushed (zero-padded) once the packet has ended.
    if (out_free_s && (state_r != IDLE) && (cnt_r != '0)) begin
      if (cnt_r >= nbps_cnt_s) begin
        extract_s = 1'b1;
      end else if (state_r == DRAIN) begin
        extract_s = 1'b1;
      end else begin
        extract_s = 1'b0;
      end
    end else begin
      extract_s = 1'b0;
    end

    if (extract_s && (state_r == DRAIN) && (cnt_r <= nbps_cnt_s)) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end

    if (extract_s) begin
      buf_after_s = buf_r >> nbps_s;
      cnt_after_s = (cnt_r >= nbps_cnt_s) ? (cnt_r - nbps_cnt_s) : '0;
    end else begin
      buf_after_s = buf_r;
      cnt_after_s = cnt_r;
    end

    word_ext_s = BUF_W'(s_tdata) << cnt_after_s;
    if (accept_s) begin
      buf_next_s = buf_after_s | word_ext_s;
      cnt_next_s = cnt_after_s + CNT_DIN;
    end else begin
      buf_next_s = buf_after_s;
      cnt_next_s = cnt_after_s;
    end

    case (state_r)
      IDLE: begin
        if (accept_s) begin
          mode_next_s  = mode_t'(cfg_mode);
          state_next_s = s_tlast ? DRAIN : RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (accept_s && s_tlast) begin
          state_next_s = DRAIN;
        end else begin
          state_next_s = RUN;
        end
      end
      DRAIN: begin
        if (last_s || (cnt_r == '0)) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DRAIN;
        end
      end
      default: state_next_s = IDLE;
    endcase

    // s_tready is registered from next-cycle state so m_tready never reaches it combinationally.
    case (state_next_s)
      IDLE:    s_tready_next_s = 1'b1;
      RUN:     s_tready_next_s = (cnt_next_s <= CNT_ROOM);
      DRAIN:   s_tready_next_s = 1'b0;
      default: s_tready_next_s = 1'b0;
    endcase

    m_tvalid_next_s = extract_s || (m_tvalid_r && !m_tready);
  end

  // Zero-pad symbol bits beyond the valid count
  always_comb begin
    if (cnt_r < CNT_W'(6)) begin
      bits_s = buf_r[5:0] & ~(6'h3F << cnt_r);
    end else begin
      bits_s = buf_r[5:0];
    end
  end

  qam_level_lut u_lut (
    .bits    (bits_s),
    .mode    (mode_r),
    .level_i (lvl_i_s),
    .level_q (lvl_q_s)
  );

  // Per-mode unit scaling of the Gray levels
  always_comb begin
    case (mode_r)
      MODE_BPSK:  unit_s = PROD_W'(UNIT_BPSK);
      MODE_QPSK:  unit_s = PROD_W'(UNIT_QPSK);
      MODE_16QAM: unit_s = PROD_W'(UNIT_16QAM);
      MODE_64QAM: unit_s = PROD_W'(UNIT_64QAM);
      default:    unit_s = PROD_W'(UNIT_BPSK);
    endcase
    prod_i_s = PROD_W'(lvl_i_s) * unit_s;
    prod_q_s = PROD_W'(lvl_q_s) * unit_s;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Bit buffer, frozen mode and registered control outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r     <= MODE_BPSK;
      buf_r      <= '0;
      cnt_r      <= '0;
      s_tready_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      mode_r     <= mode_next_s;
      buf_r      <= buf_next_s;
      cnt_r      <= cnt_next_s;
      s_tready_r <= s_tready_next_s;
      busy_r     <= (state_next_s != IDLE) || m_tvalid_next_s;
    end
  end

  // Output symbol register, held while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_i_r   <= '0;
      data_q_r   <= '0;
      m_tvalid_r <= 1'b0;
      m_tlast_r  <= 1'b0;
    end else if (extract_s) begin
      data_i_r   <= saturate(prod_i_s);
      data_q_r   <= saturate(prod_q_s);
      m_tvalid_r <= 1'b1;
      m_tlast_r  <= last_s;
    end else if (m_tready) begin
      m_tvalid_r <= 1'b0;
      m_tlast_r  <= 1'b0;
    end else begin
      m_tvalid_r <= m_tvalid_r;
      m_tlast_r  <= m_tlast_r;
    end
  end

  // Saturating per-packet symbol counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_count_r <= 16'd0;
    end else if ((state_r == IDLE) && accept_s) begin
      sym_count_r <= 16'd0;
    end else if (m_tvalid_r && m_tready && (sym_count_r != 16'hFFFF)) begin
      sym_count_r <= sym_count_r + 16'd1;
    end else begin
      sym_count_r <= sym_count_r;
    end
  end

  assign s_tready  = s_tready_r;
  assign m_tdata_i = data_i_r;
  assign m_tdata_q = data_q_r;
  assign m_tvalid  = m_tvalid_r;
  assign m_tlast   = m_tlast_r;
  assign sym_count = sym_count_r;
  assign busy      = busy_r;

endmodule
